// File: rtl/vip_color_pkg.sv
// Shared constants and helpers for the VIP colour-space stages.
// `VIP_YCBCR_LIMITED_RANGE_EN selects studio-range (BT.601 limited) coefficients instead of full range.
package vip_color_pkg;

   localparam int CHROMA_OFS = 128;
   localparam int LUMA_OFS   = 16;
   localparam int COEF_FRAC  = 8;
   localparam int SYNC_DLY   = 3;

`ifdef VIP_YCBCR_LIMITED_RANGE_EN
   localparam bit LIMITED_RANGE = 1'b1;
   localparam logic signed [19:0] K_Y  = 20'sd298;
   localparam logic signed [19:0] K_RV = 20'sd409;
   localparam logic signed [19:0] K_GU = 20'sd100;
   localparam logic signed [19:0] K_GV = 20'sd208;
   localparam logic signed [19:0] K_BU = 20'sd516;
`else
   localparam bit LIMITED_RANGE = 1'b0;
   localparam logic signed [19:0] K_Y  = 20'sd256;
   localparam logic signed [19:0] K_RV = 20'sd359;
   localparam logic signed [19:0] K_GU = 20'sd88;
   localparam logic signed [19:0] K_GV = 20'sd183;
   localparam logic signed [19:0] K_BU = 20'sd454;
`endif

   localparam logic signed [8:0] Y_OFS = LIMITED_RANGE ? 9'(LUMA_OFS) : 9'sd0;

   // Round-half-up from Q8, then clamp to 0..255 so out-of-gamut sums never wrap.
   function automatic logic [7:0] round_sat(input logic signed [19:0] sum);
      logic signed [19:0] rounded;
      logic signed [19:0] shifted;
      rounded = sum + 20'sd128;
      shifted = rounded >>> COEF_FRAC;
      if (shifted < 20'sd0)
         round_sat = 8'd0;
      else if (shifted > 20'sd255)
         round_sat = 8'd255;
      else
         round_sat = shifted[7:0];
   endfunction

endpackage

// File: rtl/vip_sync_delay.sv
// Fixed-depth shift register for frame sync/enable strobes; keeps them aligned with a datapath pipeline.
module vip_sync_delay #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [DEPTH-1:0][WIDTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst)
         sr <= '0;
      else
         sr <= {sr[DEPTH-2:0], din};
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/image_ycbcr444_rgb888.sv
// YCbCr444 -> RGB888 BT.601 matrix, 3-stage pipeline with sync strobes delayed to match.
// `VIP_YCBCR_LIMITED_RANGE_EN (via vip_color_pkg) switches to studio-range input.
module image_ycbcr444_rgb888
   import vip_color_pkg::*;
#(
   parameter bit ZERO_BLANK = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       per_frame_vsync,
   input  logic       per_frame_href,
   input  logic       per_frame_clken,
   input  logic [7:0] per_img_Y,
   input  logic [7:0] per_img_Cb,
   input  logic [7:0] per_img_Cr,
   output logic       post_frame_vsync,
   output logic       post_frame_href,
   output logic       post_frame_clken,
   output logic [7:0] post_img_red,
   output logic [7:0] post_img_green,
   output logic [7:0] post_img_blue
);

   logic signed [8:0]  y_s, cb_s, cr_s;
   logic signed [19:0] p_y, p_rv, p_gu, p_gv, p_bu;
   logic signed [19:0] sum_r, sum_g, sum_b;
   logic [7:0]         red_q, green_q, blue_q;
   logic [2:0]         sync_out;

   assign y_s  = $signed({1'b0, per_img_Y})  - Y_OFS;
   assign cb_s = $signed({1'b0, per_img_Cb}) - 9'(CHROMA_OFS);
   assign cr_s = $signed({1'b0, per_img_Cr}) - 9'(CHROMA_OFS);

   always_ff @(posedge clk) begin
      if (rst) begin
         p_y  <= '0;
         p_rv <= '0;
         p_gu <= '0;
         p_gv <= '0;
         p_bu <= '0;
      end else begin
         p_y  <= 20'(y_s)  * K_Y;
         p_rv <= 20'(cr_s) * K_RV;
         p_gu <= 20'(cb_s) * K_GU;
         p_gv <= 20'(cr_s) * K_GV;
         p_bu <= 20'(cb_s) * K_BU;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_r <= '0;
         sum_g <= '0;
         sum_b <= '0;
      end else begin
         sum_r <= p_y + p_rv;
         sum_g <= p_y - p_gu - p_gv;
         sum_b <= p_y + p_bu;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
      end else begin
         red_q   <= round_sat(sum_r);
         green_q <= round_sat(sum_g);
         blue_q  <= round_sat(sum_b);
      end
   end

   vip_sync_delay #(
      .DEPTH (SYNC_DLY),
      .WIDTH (3)
   ) u_sync_delay (
      .clk  (clk),
      .rst  (rst),
      .din  ({per_frame_vsync, per_frame_href, per_frame_clken}),
      .dout (sync_out)
   );

   assign post_frame_vsync = sync_out[2];
   assign post_frame_href  = sync_out[1];
   assign post_frame_clken = sync_out[0];

   // Blanking mask sits after the S3 registers so it lines up with the delayed href.
   assign post_img_red   = (ZERO_BLANK && !post_frame_href) ? 8'd0 : red_q;
   assign post_img_green = (ZERO_BLANK && !post_frame_href) ? 8'd0 : green_q;
   assign post_img_blue  = (ZERO_BLANK && !post_frame_href) ? 8'd0 : blue_q;

endmodule

// File: tb/tb_image_ycbcr444_rgb888.sv
// Self-checking bench for image_ycbcr444_rgb888: directed colour points plus a random frame against an arithmetic model.
module tb_image_ycbcr444_rgb888;

`ifdef VIP_YCBCR_LIMITED_RANGE_EN
   localparam int M_YOFS = 16;
   localparam int M_KY = 298, M_KRV = 409, M_KGU = 100, M_KGV = 208, M_KBU = 516;
`else
   localparam int M_YOFS = 0;
   localparam int M_KY = 256, M_KRV = 359, M_KGU = 88, M_KGV = 183, M_KBU = 454;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       per_frame_vsync = 1'b0, per_frame_href = 1'b0, per_frame_clken = 1'b0;
   logic [7:0] per_img_Y = '0, per_img_Cb = '0, per_img_Cr = '0;
   logic       post_frame_vsync, post_frame_href, post_frame_clken;
   logic [7:0] post_img_red, post_img_green, post_img_blue;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic       vs;
      logic       hr;
      logic       ck;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } exp_t;

   exp_t exp_q[$];

   image_ycbcr444_rgb888 #(.ZERO_BLANK(1'b1)) dut (
      .clk              (clk),
      .rst              (rst),
      .per_frame_vsync  (per_frame_vsync),
      .per_frame_href   (per_frame_href),
      .per_frame_clken  (per_frame_clken),
      .per_img_Y        (per_img_Y),
      .per_img_Cb       (per_img_Cb),
      .per_img_Cr       (per_img_Cr),
      .post_frame_vsync (post_frame_vsync),
      .post_frame_href  (post_frame_href),
      .post_frame_clken (post_frame_clken),
      .post_img_red     (post_img_red),
      .post_img_green   (post_img_green),
      .post_img_blue    (post_img_blue)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] ref_chan(input int sum);
      int v;
      v = (sum + 128) >>> 8;
      if (v < 0) return 8'd0;
      if (v > 255) return 8'd255;
      return v[7:0];
   endfunction

   // Apply one cycle of input; compare outputs against the entry that entered the pipe three cycles ago.
   task automatic drive(input logic vs, input logic hr, input logic ck,
                        input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                        input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
      exp_t e;
      per_frame_vsync = vs;
      per_frame_href  = hr;
      per_frame_clken = ck;
      per_img_Y  = y;
      per_img_Cb = cb;
      per_img_Cr = cr;
      exp_q.push_back('{vs: vs, hr: hr, ck: ck, r: er, g: eg, b: eb});
      @(posedge clk);
      #1;
      if (exp_q.size() >= 3) begin
         e = exp_q.pop_front();
         check("vsync", {7'd0, post_frame_vsync}, {7'd0, e.vs});
         check("href",  {7'd0, post_frame_href},  {7'd0, e.hr});
         check("clken", {7'd0, post_frame_clken}, {7'd0, e.ck});
         check("red",   post_img_red,   e.hr ? e.r : 8'd0);
         check("green", post_img_green, e.hr ? e.g : 8'd0);
         check("blue",  post_img_blue,  e.hr ? e.b : 8'd0);
      end
   endtask

   task automatic drive_rand(input logic vs, input logic hr, input logic ck);
      logic [7:0] y, cb, cr;
      int yp, cbp, crp;
      y  = 8'($urandom);
      cb = 8'($urandom);
      cr = 8'($urandom);
      yp  = int'(y) - M_YOFS;
      cbp = int'(cb) - 128;
      crp = int'(cr) - 128;
      drive(vs, hr, ck, y, cb, cr,
            ref_chan(yp * M_KY + crp * M_KRV),
            ref_chan(yp * M_KY - cbp * M_KGU - crp * M_KGV),
            ref_chan(yp * M_KY + cbp * M_KBU));
   endtask

   // One-cycle reset with live-looking inputs; everything must read zero right after.
   task automatic do_reset();
      rst = 1'b1;
      per_frame_vsync = 1'b1;
      per_frame_href  = 1'b1;
      per_frame_clken = 1'b1;
      per_img_Y  = 8'($urandom);
      per_img_Cb = 8'($urandom);
      per_img_Cr = 8'($urandom);
      @(posedge clk);
      #1;
      check("rst_vsync", {7'd0, post_frame_vsync}, 8'd0);
      check("rst_href",  {7'd0, post_frame_href},  8'd0);
      check("rst_clken", {7'd0, post_frame_clken}, 8'd0);
      check("rst_red",   post_img_red,   8'd0);
      check("rst_green", post_img_green, 8'd0);
      check("rst_blue",  post_img_blue,  8'd0);
      rst = 1'b0;
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back('0);
   endtask

   initial begin
      do_reset();

`ifndef VIP_YCBCR_LIMITED_RANGE_EN
      drive(1, 1, 1, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
      drive(1, 1, 1, 8'd76,  8'd85,  8'd255, 8'd254, 8'd0,   8'd0);
      drive(1, 1, 1, 8'd0,   8'd0,   8'd0,   8'd0,   8'd136, 8'd0);
      drive(1, 1, 1, 8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255);
`else
      drive(1, 1, 1, 8'd16,  8'd128, 8'd128, 8'd0,   8'd0,   8'd0);
      drive(1, 1, 1, 8'd235, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255);
      drive(1, 1, 1, 8'd5,   8'd128, 8'd128, 8'd0,   8'd0,   8'd0);
      drive(1, 1, 1, 8'd250, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255);
`endif
      for (int i = 0; i < 3; i++) drive_rand(0, 0, 0);

      // Random 16x4 frame with horizontal blanking gaps carrying random data.
      for (int i = 0; i < 2; i++) drive_rand(0, 0, 0);
      for (int line = 0; line < 4; line++) begin
         for (int p = 0; p < 16; p++) drive_rand(1, 1, 1'($urandom_range(0, 1)));
         for (int g = 0; g < 4; g++) drive_rand(1, 0, 0);
      end
      for (int i = 0; i < 4; i++) drive_rand(0, 0, 0);

      // Mid-line reset, then the line continues.
      for (int p = 0; p < 7; p++) drive_rand(1, 1, 1);
      do_reset();
      for (int p = 0; p < 9; p++) drive_rand(1, 1, 1);
      for (int i = 0; i < 4; i++) drive_rand(0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
